// File: rtl/memory_stage_pkg.sv
// Purpose : shared bus layouts, field offsets and state encodings for the memory stage.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
//
// The execute-stage bus (M) and writeback bus (W) are defined here once so the
// execute, memory and writeback stages all agree on the same packing.
package memory_stage_pkg;

    localparam int M_BUS_W = 41;
    localparam int W_BUS_W = 39;

    // Execute bus field LSB offsets (MSB to LSB: alu_result, store_data,
    // wr_reg, halt, regwrite, memtoreg, memread, memwrite).
    localparam int M_MEMWRITE_LSB   = 0;
    localparam int M_MEMREAD_LSB    = 1;
    localparam int M_MEMTOREG_LSB   = 2;
    localparam int M_REGWRITE_LSB   = 3;
    localparam int M_HALT_LSB       = 4;
    localparam int M_WR_REG_LSB     = 5;
    localparam int M_STORE_DATA_LSB = 9;
    localparam int M_ALU_RESULT_LSB = 25;

    // Writeback bus field LSB offsets (MSB to LSB: alu_result, mem_data,
    // wr_reg, halt, regwrite, memtoreg).
    localparam int W_MEMTOREG_LSB   = 0;
    localparam int W_REGWRITE_LSB   = 1;
    localparam int W_HALT_LSB       = 2;
    localparam int W_WR_REG_LSB     = 3;
    localparam int W_MEM_DATA_LSB   = 7;
    localparam int W_ALU_RESULT_LSB = 23;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    typedef struct packed {
        logic [15:0] alu_result;
        logic [15:0] store_data;
        logic [3:0]  wr_reg;
        logic        halt;
        logic        regwrite;
        logic        memtoreg;
        logic        memread;
        logic        memwrite;
    } m_bus_t;

    typedef struct packed {
        logic [15:0] alu_result;
        logic [15:0] mem_data;
        logic [3:0]  wr_reg;
        logic        halt;
        logic        regwrite;
        logic        memtoreg;
    } w_bus_t;

    // Build the writeback word for an instruction that retires this cycle.
    function automatic w_bus_t wb_from_m(input m_bus_t m, input logic [15:0] mem_data);
        w_bus_t w;
        w.alu_result = m.alu_result;
        w.mem_data   = mem_data;
        w.wr_reg     = m.wr_reg;
        w.halt       = m.halt;
        w.regwrite   = m.regwrite;
        w.memtoreg   = m.memtoreg;
        return w;
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Purpose : bundles the execute bus, data-memory port and writeback bus of the memory stage.
// Latency : n/a (wires only).
// Backpressure: stall_M tells the execute stage to hold M_in.
//
// Ports (master = memory stage side):
//   M_in, mem_rdata, mem_ack                         -> into the stage
//   stall_M, mem_req, mem_we, mem_addr, mem_wdata,
//   W_out, err_M                                     -> out of the stage
interface memory_stage_if;
    import memory_stage_pkg::*;

    logic [M_BUS_W-1:0] M_in;
    logic               stall_M;
    logic               mem_req;
    logic               mem_we;
    logic [15:0]        mem_addr;
    logic [15:0]        mem_wdata;
    logic [15:0]        mem_rdata;
    logic               mem_ack;
    logic [W_BUS_W-1:0] W_out;
    logic               err_M;

    modport master (
        input  M_in, mem_rdata, mem_ack,
        output stall_M, mem_req, mem_we, mem_addr, mem_wdata, W_out, err_M
    );

    modport slave (
        output M_in, mem_rdata, mem_ack,
        input  stall_M, mem_req, mem_we, mem_addr, mem_wdata, W_out, err_M
    );

endinterface

// File: rtl/memory_stage_mem_access_ctrl.sv
// Purpose : access FSM (IDLE/WAIT/HALTED), wait counter, sticky timeout flag and retire decode.
// Latency : request/stall/retire are combinational from inputs and state; state updates on the edge.
// Backpressure: stall_o holds upstream while a request is outstanding and not acked or timed out.
//
// Ports: clk, rst_n; access_i/halt_i/mem_ack_i from the current instruction and memory;
//        mem_req_o, stall_o, retire_o, ack_hit_o (ack seen with request), err_o (sticky).
module mem_access_ctrl
    import memory_stage_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic access_i,
    input  logic halt_i,
    input  logic mem_ack_i,
    output logic mem_req_o,
    output logic stall_o,
    output logic retire_o,
    output logic ack_hit_o,
    output logic err_o
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_e     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic       err_q,   err_d;

    logic       mem_req;
    logic       timeout;
    logic       ack_hit;
    logic       retire;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Output / decode logic. rst_n gates the request so it drops the moment
    // reset asserts, without waiting for the registers to settle.
    always_comb begin
        mem_req = rst_n && access_i && ((state_q == ST_IDLE) || (state_q == ST_WAIT));
        timeout = (state_q == ST_WAIT) && (count_q == MAX_WAIT_C);
        // An ack in the timeout cycle still wins: ack_hit takes priority below.
        ack_hit = mem_req && mem_ack_i;
        retire  = ((state_q == ST_IDLE) && !access_i) || ack_hit || timeout;
    end

    assign mem_req_o = mem_req;
    assign stall_o   = mem_req && !mem_ack_i && !timeout;
    assign retire_o  = retire;
    assign ack_hit_o = ack_hit;
    assign err_o     = err_q;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (access_i && !mem_ack_i) begin
                    state_d = ST_WAIT;
                    count_d = 8'd1;
                end
            end
            ST_WAIT: begin
                if (ack_hit) begin
                    state_d = ST_IDLE;
                    count_d = 8'd0;
                end else if (timeout) begin
                    // Request is dropped; the instruction retires with no data.
                    state_d = ST_IDLE;
                    count_d = 8'd0;
                    err_d   = 1'b1;
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
                count_d = 8'd0;
            end
        endcase
        // A halting instruction completes its access first, then the stage parks.
        if (retire && halt_i) begin
            state_d = ST_HALTED;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Purpose : pipeline memory stage with integrated MEM/WB register.
// Latency : 1 cycle for non-access and zero-wait accesses; N+1 for an access acked N cycles late.
// Backpressure: stall_M high while an access is outstanding; bubbles go to writeback meanwhile.
//
// Ports: clk, rst_n (async, active-low); bus (memory_stage_if.master) carrying
//        M_in, stall_M, the data-memory request/ack port, W_out and err_M.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    memory_stage_if.master        bus
);

    m_bus_t      m;
    w_bus_t      w_d, w_q;
    logic        access;
    logic        mem_req;
    logic        stall;
    logic        retire;
    logic        ack_hit;
    logic        err;
    logic [15:0] mem_data;

    assign m      = bus.M_in;
    assign access = m.memread | m.memwrite;

    mem_access_ctrl #(
        .MAX_WAIT (MAX_WAIT)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .access_i  (access),
        .halt_i    (m.halt),
        .mem_ack_i (bus.mem_ack),
        .mem_req_o (mem_req),
        .stall_o   (stall),
        .retire_o  (retire),
        .ack_hit_o (ack_hit),
        .err_o     (err)
    );

    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = m.memwrite;
    assign bus.mem_addr  = m.alu_result;
    assign bus.mem_wdata = m.store_data;
    assign bus.stall_M   = stall;
    assign bus.err_M     = err;

    // Read data is captured only for a real load that was acked; memread with
    // memwrite is a store, and timed-out accesses return zero.
    assign mem_data = (ack_hit && m.memread && !m.memwrite) ? bus.mem_rdata : 16'h0000;

    assign w_d = retire ? wb_from_m(m, mem_data) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q <= '0;
        end else begin
            w_q <= w_d;
        end
    end

    assign bus.W_out = w_q;

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    memory_stage_if bus();

    memory_stage #(
        .MAX_WAIT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [38:0] exp_q [$];
    logic [38:0] want;

    function automatic logic [40:0] mk_m(input logic [15:0] alu, input logic [15:0] sd,
                                         input logic [3:0] wr, input logic halt,
                                         input logic rw, input logic mtr,
                                         input logic mr, input logic mw);
        return {alu, sd, wr, halt, rw, mtr, mr, mw};
    endfunction

    function automatic logic [38:0] mk_w(input logic [15:0] alu, input logic [15:0] md,
                                         input logic [3:0] wr, input logic halt,
                                         input logic rw, input logic mtr);
        return {alu, md, wr, halt, rw, mtr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.M_in      = mk_m(16'h1111, 16'h2222, 4'h1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.W_out !== 39'h0) begin n_err++; $display("FAIL reset_w: got %h want 0", bus.W_out); end
        n_cmp++; if (bus.err_M !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", bus.err_M); end
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", bus.mem_req); end
        n_cmp++; if (bus.stall_M !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", bus.stall_M); end
        bus.M_in = 41'h0;
        rst_n    = 1'b1;
        tick();
    endtask

    task automatic test_add();
        bus.M_in    = mk_m(16'h1234, 16'h0000, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.mem_ack = 1'b0;
        #1;
        n_cmp++; if (bus.stall_M !== 1'b0) begin n_err++; $display("FAIL add_stall: got %b want 0", bus.stall_M); end
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL add_req: got %b want 0", bus.mem_req); end
        exp_q.push_back(mk_w(16'h1234, 16'h0000, 4'h3, 1'b0, 1'b1, 1'b0));
        tick();
        want = exp_q.pop_front();
        n_cmp++; if (bus.W_out !== want) begin n_err++; $display("FAIL add_w: got %h want %h", bus.W_out, want); end
    endtask

    task automatic test_load_zero_wait();
        bus.M_in      = mk_m(16'h0040, 16'h0000, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hBEEF;
        #1;
        n_cmp++; if (bus.stall_M !== 1'b0) begin n_err++; $display("FAIL ld0_stall: got %b want 0", bus.stall_M); end
        n_cmp++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 16'h0040}) begin
            n_err++; $display("FAIL ld0_port: got req=%b we=%b addr=%h want 1 0 0040", bus.mem_req, bus.mem_we, bus.mem_addr);
        end
        exp_q.push_back(mk_w(16'h0040, 16'hBEEF, 4'h5, 1'b0, 1'b1, 1'b1));
        tick();
        want = exp_q.pop_front();
        n_cmp++; if (bus.W_out !== want) begin n_err++; $display("FAIL ld0_w: got %h want %h", bus.W_out, want); end
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_store_wait();
        for (int i = 0; i <= 3; i++) begin
            bus.M_in      = mk_m(16'h0080, 16'h00FF, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            bus.mem_ack   = (i == 3);
            bus.mem_rdata = 16'hDEAD;
            #1;
            n_cmp++; if (bus.stall_M !== (i < 3)) begin n_err++; $display("FAIL st_stall[%0d]: got %b", i, bus.stall_M); end
            n_cmp++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 16'h0080, 16'h00FF}) begin
                n_err++; $display("FAIL st_port[%0d]: got req=%b we=%b addr=%h wdata=%h want 1 1 0080 00FF",
                                  i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
            end
            exp_q.push_back((i == 3) ? mk_w(16'h0080, 16'h0000, 4'h7, 1'b0, 1'b0, 1'b0) : 39'h0);
            tick();
            want = exp_q.pop_front();
            n_cmp++; if (bus.W_out !== want) begin n_err++; $display("FAIL st_w[%0d]: got %h want %h", i, bus.W_out, want); end
        end
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_ack_at_timeout();
        for (int i = 0; i <= 4; i++) begin
            bus.M_in      = mk_m(16'h0300, 16'h0000, 4'h8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            bus.mem_ack   = (i == 4);
            bus.mem_rdata = 16'hC0DE;
            #1;
            n_cmp++; if (bus.stall_M !== (i < 4)) begin n_err++; $display("FAIL ackto_stall[%0d]: got %b", i, bus.stall_M); end
            exp_q.push_back((i == 4) ? mk_w(16'h0300, 16'hC0DE, 4'h8, 1'b0, 1'b1, 1'b1) : 39'h0);
            tick();
            want = exp_q.pop_front();
            n_cmp++; if (bus.W_out !== want) begin n_err++; $display("FAIL ackto_w[%0d]: got %h want %h", i, bus.W_out, want); end
        end
        n_cmp++; if (bus.err_M !== 1'b0) begin n_err++; $display("FAIL ackto_err: got %b want 0", bus.err_M); end
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 12; k++) begin
            int          kind = $urandom_range(0, 3);
            int          d    = (kind == 0) ? 0 : $urandom_range(0, 3);
            logic [15:0] alu  = 16'($urandom);
            logic [15:0] sd   = 16'($urandom);
            logic [15:0] rd   = 16'($urandom);
            logic [3:0]  wr   = 4'($urandom);
            logic        rw   = (kind <= 1);
            logic        mtr  = (kind == 1);
            logic        mr   = (kind == 1) || (kind == 3);
            logic        mw   = (kind >= 2);
            for (int i = 0; i <= d; i++) begin
                bus.M_in      = mk_m(alu, sd, wr, 1'b0, rw, mtr, mr, mw);
                bus.mem_ack   = (kind == 0) ? 1'($urandom_range(0, 1)) : (i == d);
                bus.mem_rdata = rd;
                #1;
                n_cmp++; if (bus.stall_M !== ((kind != 0) && (i < d))) begin
                    n_err++; $display("FAIL b2b_stall[%0d.%0d]: got %b kind=%0d d=%0d", k, i, bus.stall_M, kind, d);
                end
                exp_q.push_back((i == d) ? mk_w(alu, (kind == 1) ? rd : 16'h0000, wr, 1'b0, rw, mtr) : 39'h0);
                tick();
                want = exp_q.pop_front();
                n_cmp++; if (bus.W_out !== want) begin n_err++; $display("FAIL b2b_w[%0d.%0d]: got %h want %h", k, i, bus.W_out, want); end
            end
        end
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_timeout();
        for (int i = 0; i <= 4; i++) begin
            bus.M_in    = mk_m(16'h0100, 16'h0000, 4'h9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            bus.mem_ack = 1'b0;
            #1;
            n_cmp++; if (bus.stall_M !== (i < 4)) begin n_err++; $display("FAIL to_stall[%0d]: got %b", i, bus.stall_M); end
            exp_q.push_back((i == 4) ? mk_w(16'h0100, 16'h0000, 4'h9, 1'b0, 1'b1, 1'b1) : 39'h0);
            tick();
            want = exp_q.pop_front();
            n_cmp++; if (bus.W_out !== want) begin n_err++; $display("FAIL to_w[%0d]: got %h want %h", i, bus.W_out, want); end
            n_cmp++; if (bus.err_M !== (i == 4)) begin n_err++; $display("FAIL to_err[%0d]: got %b", i, bus.err_M); end
        end
        // Back in IDLE: an ADD retires in one cycle with no stall.
        bus.M_in = mk_m(16'h4321, 16'h0000, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        n_cmp++; if (bus.stall_M !== 1'b0) begin n_err++; $display("FAIL to_add_stall: got %b want 0", bus.stall_M); end
        exp_q.push_back(mk_w(16'h4321, 16'h0000, 4'hA, 1'b0, 1'b1, 1'b0));
        tick();
        want = exp_q.pop_front();
        n_cmp++; if (bus.W_out !== want) begin n_err++; $display("FAIL to_add_w: got %h want %h", bus.W_out, want); end
        n_cmp++; if (bus.err_M !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %b want 1", bus.err_M); end
    endtask

    task automatic test_halt();
        bus.M_in = mk_m(16'hDEAD, 16'h0000, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        exp_q.push_back(mk_w(16'hDEAD, 16'h0000, 4'h2, 1'b1, 1'b0, 1'b0));
        tick();
        want = exp_q.pop_front();
        n_cmp++; if (bus.W_out !== want) begin n_err++; $display("FAIL halt_w: got %h want %h", bus.W_out, want); end
        for (int i = 0; i < 6; i++) begin
            bus.M_in      = (i < 3) ? mk_m(16'h1234, 16'h0000, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)
                                    : mk_m(16'h0040, 16'h0000, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 16'hBEEF;
            #1;
            n_cmp++; if ({bus.mem_req, bus.stall_M} !== 2'b00) begin
                n_err++; $display("FAIL halted_req[%0d]: got req=%b stall=%b want 0 0", i, bus.mem_req, bus.stall_M);
            end
            exp_q.push_back(39'h0);
            tick();
            want = exp_q.pop_front();
            n_cmp++; if (bus.W_out !== want) begin n_err++; $display("FAIL halted_w[%0d]: got %h want %h", i, bus.W_out, want); end
        end
        bus.mem_ack = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++; if (bus.err_M !== 1'b0) begin n_err++; $display("FAIL halt_rst_err: got %b want 0", bus.err_M); end
        bus.M_in = mk_m(16'h5555, 16'h0000, 4'hB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        exp_q.push_back(mk_w(16'h5555, 16'h0000, 4'hB, 1'b0, 1'b1, 1'b0));
        tick();
        want = exp_q.pop_front();
        n_cmp++; if (bus.W_out !== want) begin n_err++; $display("FAIL halt_after_rst_w: got %h want %h", bus.W_out, want); end
    endtask

    task automatic test_reset_mid_wait();
        bus.M_in    = mk_m(16'h0200, 16'h0000, 4'h6, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (bus.stall_M !== 1'b1) begin n_err++; $display("FAIL rmw_stall[%0d]: got %b want 1", i, bus.stall_M); end
            if (i < 2) begin
                exp_q.push_back(39'h0);
                tick();
                want = exp_q.pop_front();
                n_cmp++; if (bus.W_out !== want) begin n_err++; $display("FAIL rmw_w[%0d]: got %h want %h", i, bus.W_out, want); end
            end
        end
        // Second WAIT cycle: reset asserts mid-cycle.
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.mem_req, bus.stall_M, bus.W_out} !== 41'h0) begin
            n_err++; $display("FAIL rmw_rst: got req=%b stall=%b w=%h want all 0", bus.mem_req, bus.stall_M, bus.W_out);
        end
        tick();
        rst_n         = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h5A5A;
        #1;
        n_cmp++; if ({bus.mem_req, bus.stall_M} !== 2'b10) begin
            n_err++; $display("FAIL rmw_new_req: got req=%b stall=%b want 1 0", bus.mem_req, bus.stall_M);
        end
        exp_q.push_back(mk_w(16'h0200, 16'h5A5A, 4'h6, 1'b0, 1'b1, 1'b1));
        tick();
        want = exp_q.pop_front();
        n_cmp++; if (bus.W_out !== want) begin n_err++; $display("FAIL rmw_new_w: got %h want %h", bus.W_out, want); end
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_zero_wait();
        test_store_wait();
        test_ack_at_timeout();
        test_back_to_back();
        test_timeout();
        test_halt();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
